mul_issue_queue: RTL
====================

MUL_ISSUE_QUEUE -- requirements
Module: mul_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queue entries (power of two, 2..8).
REQ-002 SHALL have ports clk, in, 1, rising-edge clock; rst, in, 1, asynchronous active-low reset.
REQ-003 SHALL have ports flush, in, 1, discard all entries; freeze_back, in, 1, stall issue and hold outputs.
REQ-004 SHALL have dispatch port valid_dispatch, in, 1, write one new entry this cycle.
REQ-005 SHALL have dispatch port Pw_dispatch, in, 5, destination physical register.
REQ-006 SHALL have dispatch port tag_ROB_dispatch, in, 5, ROB tag.
REQ-007 SHALL have dispatch ports Pa_dispatch and Pb_dispatch, in, 5 each, source physical registers.
REQ-008 SHALL have dispatch ports rdyA_dispatch and rdyB_dispatch, in, 1 each, source already available.
REQ-009 SHALL have dispatch ports dataA_dispatch and dataB_dispatch, in, 16 each, source value when ready.
REQ-010 SHALL have broadcast ports valid_cdb[1:0], in, 2; Pw_cdb[1:0], in, 2x5; Result_cdb[1:0], in, 2x16.
REQ-011 SHALL have output full, out, 1, no free entry; count, out, 4, occupied entries.
REQ-012 SHALL have issue outputs valid_mul, out, 1; Pw_mul, out, 5; busA_mul, out, 16; busB_mul, out, 16; tag_ROB_mul, out, 5; all registered.

Function
REQ-013 SHALL keep entries in age order: index 0 oldest; new entry written at index count.
REQ-014 SHALL, on issue, remove the issued entry and shift all younger entries down by one in the same clock edge.
REQ-015 SHALL accept dispatch only when valid_dispatch=1 and full=0; dispatch with full=1 is silently dropped.
REQ-016 SHALL compute full and count from registered state only, so a same-cycle issue does not free a slot for that cycle's dispatch.
REQ-017 SHALL, for every valid entry and not-ready source, set ready and capture Result_cdb[k] when valid_cdb[k]=1 and Pw_cdb[k] equals the source tag.
REQ-018 SHALL apply the same CDB match to a dispatching entry's not-ready sources in the dispatch cycle (bypass capture).
REQ-019 SHALL give CDB port 0 priority when both ports match the same source in one cycle.
REQ-020 SHALL treat physical register 0 as always ready: a source tag of 0 is marked ready on dispatch, with value forced to 0.
REQ-021 SHALL select, each cycle, the lowest-index entry whose two sources are ready in registered state; wakeup or dispatch in cycle N makes an entry selectable in cycle N+1 at the earliest.
REQ-022 SHALL, when a selection exists and freeze_back=0, remove that entry and register valid_mul=1 with its Pw, operands and ROB tag on the same edge (issue latency 1 cycle).
REQ-023 SHALL register valid_mul=0 when no entry is selectable and freeze_back=0; other issue outputs then hold their previous values.
REQ-024 SHALL, while freeze_back=1, hold all issue outputs and block issue.
REQ-025 SHALL continue dispatch and CDB capture while freeze_back=1.
REQ-026 SHALL issue at most one entry per cycle.
REQ-027 SHALL, when flush=1 at a clock edge, clear all entry valid bits, count, valid_mul and all issue outputs to 0, overriding dispatch, issue and freeze_back.
REQ-028 SHALL pass Pw=0 through unchanged; exception marking is the consumer's job.

Reset
REQ-029 SHALL on rst=0 immediately clear all entries, count=0, full=0, valid_mul=0, and Pw_mul, busA_mul, busB_mul, tag_ROB_mul to 0, regardless of clk.
REQ-030 SHALL, on reset assertion mid-operation, discard any in-flight issue; the first valid_mul after release comes from a post-reset dispatch.

Verification
REQ-031 SHALL cover ready dispatch: Pw=3, A=7, B=6 both ready, tag=2 at cycle 0 -> valid_mul=1, Pw_mul=3, busA=7, busB=6, tag_ROB_mul=2 registered at cycle 2 edge; count returns 0.
REQ-032 SHALL cover wakeup: entry waits on Pa=9; CDB port 1 broadcasts Pw=9, Result=0x0042 -> issue next cycle with busA_mul=0x0042.
REQ-033 SHALL cover age order: E0 waits, E1 ready, then E0 wakes -> E1 issues first, then E0; the shift preserves E0 at index 0.
REQ-034 SHALL cover full: 4 dispatches -> full=1; a 5th dispatch concurrent with an issue is dropped and count=3 next cycle.
REQ-035 SHALL cover freeze_back=1 for 3 cycles with ready entries -> outputs frozen and no removal, then in-order issue resumes.
REQ-036 SHALL cover flush and async reset mid-stream -> count=0 and valid_mul=0 immediately after; no stale entry issues afterward.

Source files
------------

// File: rtl/mul_issue_queue.sv
// mul_issue_queue: age-ordered issue queue feeding a multiplier.
//
// Entries are kept compacted with index 0 the oldest. Each cycle the oldest
// entry whose two source operands are ready (registered state) is selected;
// when freeze_back is low it is removed, younger entries slide down one slot,
// and its destination, operands and ROB tag are registered onto the issue
// outputs. Not-ready sources snoop two CDB ports (port 0 wins on a double
// match), including sources of the entry being dispatched this cycle.
// Physical register 0 is always ready with value 0.
//
// Ports:
//   clk, rst (async, active-low)       clock and reset
//   flush                              drop every entry and clear issue outputs
//   freeze_back                        hold issue outputs, block issue
//   valid_dispatch .. dataB_dispatch   one new entry per cycle
//   valid_cdb, Pw_cdb, Result_cdb      two result broadcast ports
//   full, count                        occupancy from registered state
//   valid_mul, Pw_mul, busA_mul,
//   busB_mul, tag_ROB_mul              registered issue outputs
module mul_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             freeze_back,
    input  logic             valid_dispatch,
    input  logic [4:0]       Pw_dispatch,
    input  logic [4:0]       tag_ROB_dispatch,
    input  logic [4:0]       Pa_dispatch,
    input  logic [4:0]       Pb_dispatch,
    input  logic             rdyA_dispatch,
    input  logic             rdyB_dispatch,
    input  logic [15:0]      dataA_dispatch,
    input  logic [15:0]      dataB_dispatch,
    input  logic [1:0]       valid_cdb,
    input  logic [1:0][4:0]  Pw_cdb,
    input  logic [1:0][15:0] Result_cdb,
    output logic             full,
    output logic [3:0]       count,
    output logic             valid_mul,
    output logic [4:0]       Pw_mul,
    output logic [15:0]      busA_mul,
    output logic [15:0]      busB_mul,
    output logic [4:0]       tag_ROB_mul
);

    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]  pw;
        logic [4:0]  tag;
        logic [4:0]  pa;
        logic [4:0]  pb;
        logic        rdy_a;
        logic        rdy_b;
        logic [15:0] data_a;
        logic [15:0] data_b;
    } entry_t;

    entry_t [DEPTH-1:0] q;
    entry_t [DEPTH-1:0] woken;
    entry_t [DEPTH-1:0] q_next;
    entry_t             sel_entry;
    entry_t             new_entry;
    logic               sel_found;
    logic [3:0]         sel_idx;
    logic               issue;
    logic               accept;
    logic [3:0]         count_after;
    logic [3:0]         count_next;

    // Returns {ready, data} for one source after snooping both CDB ports.
    function automatic logic [16:0] capture(
        input logic              rdy,
        input logic [4:0]        src,
        input logic [15:0]       data,
        input logic [1:0]        vc,
        input logic [1:0][4:0]   pc,
        input logic [1:0][15:0]  rc
    );
        logic [16:0] r;
        r = {rdy, data};
        if (!rdy) begin
            if (vc[0] && (pc[0] == src))
                r = {1'b1, rc[0]};
            else if (vc[1] && (pc[1] == src))
                r = {1'b1, rc[1]};
        end
        return r;
    endfunction

    assign full   = (count == 4'(DEPTH));
    assign accept = valid_dispatch && !full;
    assign issue  = sel_found && !freeze_back;

    // Oldest occupied entry with both sources ready.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_entry = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!sel_found && (i < 32'(count)) &&
                q[IW'(i)].rdy_a && q[IW'(i)].rdy_b) begin
                sel_found = 1'b1;
                sel_idx   = 4'(i);
                sel_entry = q[IW'(i)];
            end
        end
    end

    // Incoming entry: register 0 forced ready/zero, then bypass capture.
    always_comb begin
        new_entry     = '0;
        new_entry.pw  = Pw_dispatch;
        new_entry.tag = tag_ROB_dispatch;
        new_entry.pa  = Pa_dispatch;
        new_entry.pb  = Pb_dispatch;
        {new_entry.rdy_a, new_entry.data_a} = capture(
            rdyA_dispatch || (Pa_dispatch == 5'd0), Pa_dispatch,
            (Pa_dispatch == 5'd0) ? 16'd0 : dataA_dispatch,
            valid_cdb, Pw_cdb, Result_cdb);
        {new_entry.rdy_b, new_entry.data_b} = capture(
            rdyB_dispatch || (Pb_dispatch == 5'd0), Pb_dispatch,
            (Pb_dispatch == 5'd0) ? 16'd0 : dataB_dispatch,
            valid_cdb, Pw_cdb, Result_cdb);
    end

    // CDB wakeup of stored entries; slots at or above count are don't-care.
    always_comb begin
        woken = q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            {woken[IW'(i)].rdy_a, woken[IW'(i)].data_a} = capture(
                q[IW'(i)].rdy_a, q[IW'(i)].pa, q[IW'(i)].data_a,
                valid_cdb, Pw_cdb, Result_cdb);
            {woken[IW'(i)].rdy_b, woken[IW'(i)].data_b} = capture(
                q[IW'(i)].rdy_b, q[IW'(i)].pb, q[IW'(i)].data_b,
                valid_cdb, Pw_cdb, Result_cdb);
        end
    end

    // Removal compacts younger entries downward; the new entry then lands
    // just above the post-removal occupancy so age order is preserved.
    always_comb begin
        q_next = woken;
        if (issue) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                if (4'(i) >= sel_idx)
                    q_next[IW'(i)] = woken[IW'(i + 1)];
            end
        end
        count_after = count - {3'b000, issue};
        if (accept) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (4'(i) == count_after)
                    q_next[IW'(i)] = new_entry;
            end
        end
        count_next = count_after + {3'b000, accept};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q           <= '0;
            count       <= '0;
            valid_mul   <= 1'b0;
            Pw_mul      <= '0;
            busA_mul    <= '0;
            busB_mul    <= '0;
            tag_ROB_mul <= '0;
        end else if (flush) begin
            q           <= '0;
            count       <= '0;
            valid_mul   <= 1'b0;
            Pw_mul      <= '0;
            busA_mul    <= '0;
            busB_mul    <= '0;
            tag_ROB_mul <= '0;
        end else begin
            q     <= q_next;
            count <= count_next;
            if (!freeze_back) begin
                valid_mul <= sel_found;
                if (sel_found) begin
                    Pw_mul      <= sel_entry.pw;
                    busA_mul    <= sel_entry.data_a;
                    busB_mul    <= sel_entry.data_b;
                    tag_ROB_mul <= sel_entry.tag;
                end
            end
        end
    end

endmodule
